// File: rtl/max7219_pkg.sv
// Shared register addresses and state encodings for the MAX7219 chain driver.
package max7219_pkg;

    localparam logic [7:0] REG_DIGIT0     = 8'h01;
    localparam logic [7:0] REG_DECODE     = 8'h09;
    localparam logic [7:0] REG_INTENSITY  = 8'h0A;
    localparam logic [7:0] REG_SCAN_LIMIT = 8'h0B;
    localparam logic [7:0] REG_SHUTDOWN   = 8'h0C;
    localparam logic [7:0] REG_TEST       = 8'h0F;

    // Word indices into the full 14-word init+rows list
    localparam logic [3:0] IDX_INTENSITY = 4'd4;
    localparam logic [3:0] IDX_ROW0      = 4'd6;
    localparam logic [3:0] IDX_LAST      = 4'd13;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_CS_SETUP,
        TX_SHIFT_LO,
        TX_SHIFT_HI,
        TX_CS_TAIL,
        TX_GAP
    } tx_state_t;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_SEND,
        FR_DONE
    } frame_state_t;

    function automatic logic [15:0] reg_word(input logic [7:0] addr, input logic [7:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/max7219_spi_tx.sv
// Shifts one W-bit word out over sck/mosi/cs, MSB first, and pulses done after the cs-high gap.
module max7219_spi_tx
    import max7219_pkg::*;
#(
    parameter int W       = 64,
    parameter int CLK_DIV = 5,
    parameter int CS_GAP  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [W-1:0] word,
    output logic         sck,
    output logic         mosi,
    output logic         cs,
    output logic         done
);

    localparam int MAXC = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int BW   = $clog2(W);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);

    tx_state_t     state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_cnt;
    logic [W-1:0]  shreg;

    // mosi only ever moves on the edge that leaves sck low, so it is stable across every rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= TX_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            cs      <= 1'b1;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (go) begin
                        shreg   <= word;
                        cs      <= 1'b0;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= TX_CS_SETUP;
                    end
                end
                TX_CS_SETUP: begin
                    if (cnt == DIV_LAST) begin
                        cnt   <= '0;
                        mosi  <= shreg[W-1];
                        state <= TX_SHIFT_LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_SHIFT_LO: begin
                    if (cnt == DIV_LAST) begin
                        cnt   <= '0;
                        sck   <= 1'b1;
                        state <= TX_SHIFT_HI;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_SHIFT_HI: begin
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        sck <= 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= TX_CS_TAIL;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg << 1;
                            mosi    <= shreg[W-2];
                            state   <= TX_SHIFT_LO;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_CS_TAIL: begin
                    if (cnt == DIV_LAST) begin
                        cnt   <= '0;
                        cs    <= 1'b1;
                        mosi  <= 1'b0;
                        state <= TX_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt   <= '0;
                        done  <= 1'b1;
                        state <= TX_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/max7219_chain_driver.sv
// Frame sequencer for a chain of MAX7219 matrices: init list once, then 8 row loads per frame.
// Define MAX7219_FRAME_LATCH_EN to snapshot pixels at start for tear-free frames.
module max7219_chain_driver
    import max7219_pkg::*;
#(
    parameter int N_DEV      = 4,
    parameter int CLK_DIV    = 5,
    parameter int CS_GAP     = 4,
    parameter int SCAN_LIMIT = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [64*N_DEV-1:0]  pixels,
    input  logic [3:0]           intensity,
    input  logic                 start,
    output logic                 busy,
    output logic                 finish,
    output logic                 sck,
    output logic                 mosi,
    output logic                 cs
);

    localparam int W  = 16 * N_DEV;
    localparam int PW = 64 * N_DEV;

    frame_state_t  state;
    logic [3:0]    word_idx;
    logic          go;
    logic          tx_done;
    logic          init_done;
    logic          intensity_pending;
    logic [3:0]    last_intensity;
    logic [15:0]   cfg_word;
    logic [2:0]    row_sel;
    logic [W-1:0]  tx_word;
    logic [PW-1:0] pix_src;

`ifdef MAX7219_FRAME_LATCH_EN
    logic [PW-1:0] shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (state == FR_IDLE && start) begin
            shadow <= pixels;
        end
    end

    assign pix_src = shadow;
`else
    assign pix_src = pixels;
`endif

    // Config words go to every device alike; row words carry each device's own byte
    always_comb begin
        cfg_word = 16'h0000;
        tx_word  = '0;
        row_sel  = 3'(word_idx - IDX_ROW0);
        case (word_idx)
            4'd0:    cfg_word = reg_word(REG_SHUTDOWN, 8'h00);
            4'd1:    cfg_word = reg_word(REG_TEST, 8'h00);
            4'd2:    cfg_word = reg_word(REG_DECODE, 8'h00);
            4'd3:    cfg_word = reg_word(REG_SCAN_LIMIT, 8'(SCAN_LIMIT));
            4'd4:    cfg_word = reg_word(REG_INTENSITY, {4'h0, intensity});
            4'd5:    cfg_word = reg_word(REG_SHUTDOWN, 8'h01);
            default: cfg_word = 16'h0000;
        endcase
        for (int d = 0; d < N_DEV; d++) begin
            if (word_idx >= IDX_ROW0) begin
                tx_word[16*d +: 16] = reg_word(REG_DIGIT0 + {5'b0, row_sel},
                                               pix_src[64*d + 8*int'(row_sel) +: 8]);
            end else begin
                tx_word[16*d +: 16] = cfg_word;
            end
        end
    end

    // Later frames enter at the intensity word only when a new brightness is waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FR_IDLE;
            word_idx  <= 4'd0;
            go        <= 1'b0;
            busy      <= 1'b0;
            finish    <= 1'b0;
            init_done <= 1'b0;
        end else begin
            go     <= 1'b0;
            finish <= 1'b0;
            case (state)
                FR_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        go    <= 1'b1;
                        state <= FR_SEND;
                        if (!init_done) begin
                            word_idx <= 4'd0;
                        end else if (intensity_pending) begin
                            word_idx <= IDX_INTENSITY;
                        end else begin
                            word_idx <= IDX_ROW0;
                        end
                    end
                end
                FR_SEND: begin
                    if (tx_done) begin
                        if (word_idx == IDX_LAST) begin
                            busy      <= 1'b0;
                            finish    <= 1'b1;
                            init_done <= 1'b1;
                            state     <= FR_DONE;
                        end else begin
                            go <= 1'b1;
                            if (word_idx == IDX_INTENSITY && init_done) begin
                                word_idx <= IDX_ROW0;
                            end else begin
                                word_idx <= word_idx + 4'd1;
                            end
                        end
                    end
                end
                FR_DONE: state <= FR_IDLE;
                default: state <= FR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            intensity_pending <= 1'b0;
            last_intensity    <= 4'h0;
        end else if (go && word_idx == IDX_INTENSITY) begin
            intensity_pending <= 1'b0;
            last_intensity    <= intensity;
        end else if (intensity != last_intensity) begin
            intensity_pending <= 1'b1;
        end
    end

    max7219_spi_tx #(
        .W       (W),
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) u_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (go),
        .word  (tx_word),
        .sck   (sck),
        .mosi  (mosi),
        .cs    (cs),
        .done  (tx_done)
    );

endmodule

// File: tb/tb_max7219_chain_driver.sv
// Scoreboard bench for max7219_chain_driver: a frame-level model queues expected SPI windows, a monitor decodes the pins.
module tb_max7219_chain_driver;

    localparam int N_DEV      = 2;
    localparam int CLK_DIV    = 2;
    localparam int CS_GAP     = 4;
    localparam int SCAN_LIMIT = 7;
    localparam int PW         = 64 * N_DEV;
    localparam int NB         = 16 * N_DEV;
    localparam int BUDGET     = 6000;

`ifdef MAX7219_FRAME_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] pixels = '0;
    logic [3:0]    intensity = 4'h0;
    logic          busy, finish, sck, mosi, cs;

    max7219_chain_driver #(
        .N_DEV      (N_DEV),
        .CLK_DIV    (CLK_DIV),
        .CS_GAP     (CS_GAP),
        .SCAN_LIMIT (SCAN_LIMIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pixels    (pixels),
        .intensity (intensity),
        .start     (start),
        .busy      (busy),
        .finish    (finish),
        .sck       (sck),
        .mosi      (mosi),
        .cs        (cs)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    logic [NB-1:0] exp_q[$];
    bit         m_init_done = 1'b0;
    logic [3:0] m_last_int  = 4'h0;

    int cyc = 0, win_count = 0, sck_rises = 0, nbits = 0;
    int cs_fall_cyc = 0, cs_rise_cyc = 0, last_rise_cyc = 0, last_fall_cyc = 0;
    bit in_win = 1'b0, tmg_ok = 1'b0, have_rise = 1'b0;
    logic prev_cs = 1'b1, prev_sck = 1'b0, prev_mosi = 1'b0;
    logic [NB-1:0] rx = '0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [PW-1:0] rand_pix();
        logic [PW-1:0] p;
        for (int i = 0; i < PW / 32; i++) p[32*i +: 32] = $urandom;
        return p;
    endfunction

    function automatic logic [NB-1:0] all_dev(input logic [7:0] addr, input logic [7:0] data);
        logic [NB-1:0] w;
        for (int d = 0; d < N_DEV; d++) w[16*d +: 16] = {addr, data};
        return w;
    endfunction

    // Expected window list for one frame, straight from the display protocol
    task automatic pushFrame(input logic [PW-1:0] oldp, input logic [PW-1:0] newp,
                             input int chg, output int n);
        logic [PW-1:0] src;
        logic [NB-1:0] w;
        int j;
        j = 0;
        if (!m_init_done) begin
            exp_q.push_back(all_dev(8'h0C, 8'h00));
            exp_q.push_back(all_dev(8'h0F, 8'h00));
            exp_q.push_back(all_dev(8'h09, 8'h00));
            exp_q.push_back(all_dev(8'h0B, 8'(SCAN_LIMIT)));
            exp_q.push_back(all_dev(8'h0A, {4'h0, intensity}));
            exp_q.push_back(all_dev(8'h0C, 8'h01));
            j = 6;
            m_init_done = 1'b1;
            m_last_int  = intensity;
        end else if (intensity != m_last_int) begin
            exp_q.push_back(all_dev(8'h0A, {4'h0, intensity}));
            j = 1;
            m_last_int = intensity;
        end
        for (int r = 0; r < 8; r++) begin
            src = (!LATCH && chg >= 0 && j >= chg) ? newp : oldp;
            for (int d = 0; d < N_DEV; d++) w[16*d +: 16] = {8'(r + 1), src[64*d + 8*r +: 8]};
            exp_q.push_back(w);
            j++;
        end
        n = j;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (!prev_sck && sck) sck_rises++;
        if (!rst_n) begin
            in_win = 1'b0;
        end else begin
            if (prev_cs && !cs) begin
                in_win      = 1'b1;
                nbits       = 0;
                rx          = '0;
                tmg_ok      = 1'b1;
                cs_fall_cyc = cyc;
                if (have_rise && (cyc - cs_rise_cyc) < CS_GAP) tmg_ok = 1'b0;
            end
            if (in_win) begin
                if (!prev_sck && sck) begin
                    if (nbits == 0 && (cyc - cs_fall_cyc) != 2 * CLK_DIV) tmg_ok = 1'b0;
                    if (nbits != 0 && (cyc - last_rise_cyc) != 2 * CLK_DIV) tmg_ok = 1'b0;
                    rx = {rx[NB-2:0], mosi};
                    nbits++;
                    last_rise_cyc = cyc;
                end
                if (prev_sck && sck && mosi != prev_mosi) tmg_ok = 1'b0;
                if (prev_sck && !sck) last_fall_cyc = cyc;
            end
            if (!prev_cs && cs && in_win) begin
                in_win = 1'b0;
                if ((cyc - last_fall_cyc) != CLK_DIV) tmg_ok = 1'b0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("[TB] FAIL unexpected_window: got %0h with nothing expected", rx);
                end else begin
                    checkOutput("window_data", rx, exp_q.pop_front());
                end
                checkOutput("window_bits", nbits, NB);
                checkOutput("window_timing", tmg_ok, 1);
                cs_rise_cyc = cyc;
                have_rise   = 1'b1;
                win_count++;
            end
        end
        prev_cs   = cs;
        prev_sck  = sck;
        prev_mosi = mosi;
    end

    task automatic waitFinish(input int chg, input logic [PW-1:0] nxt, input int base,
                              input bit mid_start, input bit hold_start, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            tick();
            if (finish) begin
                ok = 1'b1;
                break;
            end
            if (mid_start) start = ((win_count - base) == 2) ? 1'b1 : hold_start;
            if (chg >= 0 && (win_count - base) >= chg) pixels = nxt;
        end
    endtask

    task automatic applyStimulus(input int exp_windows, input int chg,
                                 input bit mid_start, input bit hold_start);
        logic [PW-1:0] nxt;
        int n_model, n2, base;
        bit ok;
        nxt = rand_pix();
        repeat (2) tick();
        pushFrame(pixels, nxt, chg, n_model);
        base  = win_count;
        start = 1'b1;
        tick();
        checkOutput("busy_on_accept", busy, 1);
        start = hold_start;
        waitFinish(chg, nxt, base, mid_start, hold_start, ok);
        checkOutput("finish_seen", ok, 1);
        if (ok) begin
            checkOutput("busy_at_finish", busy, 0);
            checkOutput("window_count", win_count - base, (exp_windows >= 0) ? exp_windows : n_model);
            tick();
            checkOutput("finish_one_cycle", finish, 0);
            checkOutput("busy_after_finish", busy, 0);
            if (hold_start) begin
                pushFrame(pixels, pixels, -1, n2);
                base = win_count;
                tick();
                checkOutput("busy_rehold", busy, 1);
                start = 1'b0;
                waitFinish(-1, pixels, base, 1'b0, 1'b0, ok);
                checkOutput("finish_seen2", ok, 1);
                checkOutput("window_count2", win_count - base, n2);
                tick();
            end
        end
        start = 1'b0;
    endtask

    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, base;
        bit reached;

        pixels    = rand_pix();
        intensity = 4'h8;
        start     = 1'b1;
        rst_n     = 1'b0;
        repeat (10) tick();
        checkOutput("reset_cs", cs, 1);
        checkOutput("reset_sck", sck, 0);
        checkOutput("reset_mosi", mosi, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_finish", finish, 0);
        checkOutput("reset_no_sck", sck_rises, 0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) tick();

        $display("[TB] init frame");
        pixels[64*1 +: 8] = 8'hA5;
        pixels[0 +: 8]    = 8'h3C;
        applyStimulus(14, -1, 1'b0, 1'b0);

        $display("[TB] frame with unchanged intensity");
        pixels = rand_pix();
        applyStimulus(8, -1, 1'b0, 1'b0);

        $display("[TB] frame after intensity change");
        intensity = 4'h2;
        pixels    = rand_pix();
        applyStimulus(9, -1, 1'b0, 1'b0);

        $display("[TB] start pulsed mid-frame");
        applyStimulus(8, -1, 1'b1, 1'b0);

        $display("[TB] pixels change after third window");
        pixels = rand_pix();
        applyStimulus(8, 3, 1'b0, 1'b0);

        $display("[TB] start held through finish");
        intensity = 4'hF;
        applyStimulus(9, -1, 1'b0, 1'b1);

        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 1) == 1) intensity = 4'($urandom);
            pixels = rand_pix();
            applyStimulus(-1, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : -1, 1'b0, 1'b0);
        end

        $display("[TB] reset during shift");
        pixels = rand_pix();
        repeat (2) tick();
        pushFrame(pixels, pixels, -1, n);
        base  = win_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            if (in_win && nbits >= 10 && (win_count - base) >= 1) begin
                reached = 1'b1;
                break;
            end
            tick();
        end
        checkOutput("reached_mid_shift", reached, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_cs", cs, 1);
        checkOutput("abort_sck", sck, 0);
        checkOutput("abort_mosi", mosi, 0);
        checkOutput("abort_busy", busy, 0);
        exp_q.delete();
        m_init_done = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        applyStimulus(14, -1, 1'b0, 1'b0);

        repeat (5) tick();
        checkOutput("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
